sdram_host_bridge: RTL and testbench

- Host-side front end placed directly upstream of the SDRAM controller.
- Accepts read/write commands over a valid/ready interface and queues them in a small FIFO.
- Converts each command into the controller's edge-triggered request protocol: request and write_enable rise together, then a 1-cycle response pulse comes back.
- Returns read data or write completion to the host, with a response timeout and an error counter.

---
 rtl/sdram_host_bridge.sv | 137 +++++++++++++
 tb/tb_sdram_host_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_bridge.sv
// sdram_host_bridge: queues host read/write commands and sequences them one at a time onto the SDRAM controller request/response handshake
module sdram_host_bridge #(
    parameter int FIFO_DEPTH       = 4,
    parameter int INIT_WAIT_CYCLES = 26000,
    parameter int REQ_HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES       = 2,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [24:0] cmd_address,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        init_done,
    output logic        busy,
    output logic [7:0]  err_count,
    output logic        mem_request,
    output logic        mem_write_enable,
    output logic [24:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic        mem_response,
    input  logic [31:0] mem_read_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int M1 = INIT_WAIT_CYCLES > TIMEOUT_CYCLES ? INIT_WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int M2 = REQ_HOLD_CYCLES > GAP_CYCLES ? REQ_HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ASSERT, S_WAIT_RSP, S_GAP} state_t;

    state_t state, state_next;
    logic [57:0] fifo_mem [FIFO_DEPTH];
    logic [57:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [CW-1:0] cnt;
    logic push, pop, cnt_done, cnt_clear, got_rsp, timeout, work_write;

    assign cmd_ready = count != (AW+1)'(FIFO_DEPTH);
    assign push = cmd_valid && cmd_ready;
    assign head = fifo_mem[rd_ptr];
    assign busy = |count || !(state == S_IDLE || state == S_INIT);
    assign cnt_done = (state == S_INIT)     ? cnt == CW'(INIT_WAIT_CYCLES - 1) :
                      (state == S_ASSERT)   ? cnt == CW'(REQ_HOLD_CYCLES - 1) :
                      (state == S_WAIT_RSP) ? cnt == CW'(TIMEOUT_CYCLES - 1) :
                                              cnt == CW'(GAP_CYCLES - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:     if (cnt_done) state_next = S_IDLE;
            S_IDLE:     if (|count) state_next = S_ASSERT;
            S_ASSERT:   if (cnt_done) state_next = S_WAIT_RSP;
            S_WAIT_RSP: if (mem_response || cnt_done) state_next = S_GAP;
            S_GAP:      if (cnt_done) state_next = S_IDLE;
            default:    state_next = S_INIT;
        endcase
    end

    always_comb begin
        pop = state == S_IDLE && |count;
        got_rsp = state == S_WAIT_RSP && mem_response;
        timeout = state == S_WAIT_RSP && !mem_response && cnt_done;
        cnt_clear = state_next != state || state == S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {cmd_write, cmd_address, cmd_wdata};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            init_done <= 1'b0;
            mem_request <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address <= '0;
            mem_write_data <= '0;
            work_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            err_count <= '0;
        end else begin
            cnt <= cnt_clear ? '0 : cnt + 1'b1;
            rsp_valid <= got_rsp || timeout;
            if (state == S_INIT && cnt_done)
                init_done <= 1'b1;
            if (pop) begin
                mem_request <= 1'b1;
                mem_write_enable <= head[57];
                mem_address <= head[56:32];
                mem_write_data <= head[31:0];
                work_write <= head[57];
            end else if (state == S_ASSERT && cnt_done) begin
                mem_request <= 1'b0;
                mem_write_enable <= 1'b0;
            end
            if (got_rsp || timeout) begin
                rsp_write <= work_write;
                rsp_rdata <= (work_write || timeout) ? '0 : mem_read_data;
                rsp_error <= timeout;
            end
            if (timeout && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_host_bridge.sv
// tb_sdram_host_bridge: randomized scoreboard bench with a behavioural controller/memory model
module tb_sdram_host_bridge;
    localparam int DEPTH = 4, INIT = 30, HOLD = 2, GAP = 2, TMO = 64;

    logic        clock = 0, reset = 1;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [24:0] cmd_address = 0;
    logic [31:0] cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_write, rsp_error, init_done, busy;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;
    logic        mem_request, mem_write_enable;
    logic [24:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_response = 0;
    logic [31:0] mem_read_data = 0;

    sdram_host_bridge #(
        .FIFO_DEPTH(DEPTH), .INIT_WAIT_CYCLES(INIT), .REQ_HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .init_done(init_done), .busy(busy), .err_count(err_count),
        .mem_request(mem_request), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_response(mem_response), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [24:0] a;
        logic [31:0] d;
        logic        drop;
        int          lat;
    } cmd_t;
    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    cmd_t req_q[$];
    rsp_t exp_q[$];
    logic [31:0] ref_mem [logic [24:0]];
    logic [31:0] dev_mem [logic [24:0]];
    logic [24:0] addrs [8] = '{25'h0000000, 25'h0000400, 25'h1FFFFFF, 25'h0800123,
                               25'h1000001, 25'h17FE3FF, 25'h0000123, 25'h0ABCDEF};
    int   errors = 0, checks = 0, model_errs = 0;
    logic stray_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [24:0] a);
        return {7'd0, a} ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [24:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [24:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    // The reference model resolves each accepted command in order: writes update memory, reads see the latest write.
    task automatic push(input logic w, input logic [24:0] a, input logic [31:0] d, input logic drop, input int lat);
        cmd_t c;
        rsp_t e;
        logic r;
        int   n;
        c = '{w, a, d, drop, lat};
        cmd_valid = 1;
        cmd_write = w;
        cmd_address = a;
        cmd_wdata = d;
        n = 0;
        do begin
            @(negedge clock);
            r = cmd_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!r && n < 3000);
        cmd_valid = 0;
        check("push_accepted", {31'd0, r}, 1);
        if (r) begin
            req_q.push_back(c);
            e.w = w;
            e.err = drop;
            e.rdata = 0;
            if (!drop) begin
                if (w)
                    ref_mem[a] = d;
                else
                    e.rdata = ref_rd(a);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        #1;
        check("drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_request"}, {31'd0, mem_request}, 0);
        check({tag, "_mem_write_enable"}, {31'd0, mem_write_enable}, 0);
        check({tag, "_mem_address"}, {7'd0, mem_address}, 0);
        check({tag, "_mem_write_data"}, mem_write_data, 0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
        check({tag, "_rsp_write"}, {31'd0, rsp_write}, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_error"}, {31'd0, rsp_error}, 0);
        check({tag, "_init_done"}, {31'd0, init_done}, 0);
        check({tag, "_err_count"}, {24'd0, err_count}, 0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
        check({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    // Monitor, controller responder and scoreboard, all evaluated at the falling edge.
    cmd_t cur;
    rsp_t got;
    logic prev_req = 0, waiting = 0, have_prev = 0, cur_we = 0;
    int   cyc = 0, hold = 0, low = 0, cd = 0, fall_cyc = 0, resp_cyc = 0;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            mem_response = 0;
            mem_read_data = 0;
            if (reset) begin
                prev_req = 0;
                waiting = 0;
                have_prev = 0;
                hold = 0;
                low = 0;
            end else begin
                if (mem_request && !prev_req) begin
                    check("req_after_init", {31'd0, init_done}, 1);
                    if (have_prev)
                        check("req_gap_ok", {31'd0, low >= GAP}, 1);
                    check("req_expected", {31'd0, req_q.size() > 0}, 1);
                    if (req_q.size() > 0) begin
                        cur = req_q.pop_front();
                        cd = cur.lat;
                    end
                    cur_we = mem_write_enable;
                    hold = 0;
                    low = 0;
                    have_prev = 1;
                end
                if (mem_request) begin
                    hold++;
                    check("req_write_enable", {31'd0, mem_write_enable}, {31'd0, cur.w});
                    check("req_address", {7'd0, mem_address}, {7'd0, cur.a});
                    check("req_write_data", mem_write_data, cur.d);
                end else begin
                    low++;
                    check("we_without_req", {31'd0, mem_write_enable}, 0);
                end
                if (!mem_request && prev_req) begin
                    check("req_hold", hold, HOLD);
                    fall_cyc = cyc;
                    waiting = 1;
                end
                if (waiting && !cur.drop) begin
                    if (cd == 0) begin
                        mem_response = 1;
                        if (cur_we) begin
                            dev_mem[mem_address] = mem_write_data;
                            mem_read_data = $urandom;
                        end else
                            mem_read_data = dev_rd(mem_address);
                        waiting = 0;
                        resp_cyc = cyc;
                    end else
                        cd--;
                end
                if (stray_req) begin
                    mem_response = 1;
                    mem_read_data = 32'hBAD0BAD0;
                    stray_req = 0;
                end
                if (rsp_valid) begin
                    check("rsp_expected", {31'd0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        check("rsp_write", {31'd0, rsp_write}, {31'd0, got.w});
                        check("rsp_rdata", rsp_rdata, got.rdata);
                        check("rsp_error", {31'd0, rsp_error}, {31'd0, got.err});
                        if (got.err) begin
                            if (model_errs < 255)
                                model_errs++;
                            check("timeout_latency", cyc - fall_cyc, TMO);
                        end else
                            check("rsp_latency", cyc - resp_cyc, 1);
                        check("err_count", {24'd0, err_count}, model_errs);
                        waiting = 0;
                    end
                end
                prev_req = mem_request;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        ref_mem[25'h1FFFFFF] = 32'h12345678;
        dev_mem[25'h1FFFFFF] = 32'h12345678;
        reset = 1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("por");
        reset = 0;

        push(1, 25'h0000400, 32'hDEADBEEF, 0, 5);
        push(0, 25'h1FFFFFF, 32'h0, 0, 3);
        push(1, 25'h0000123, 32'hCAFEF00D, 1, 0);
        push(1, 25'h0000123, 32'h0BADF00D, 0, 2);
        check("full_cmd_ready", {31'd0, cmd_ready}, 0);
        check("full_still_init", {31'd0, init_done}, 0);
        check("full_busy", {31'd0, busy}, 1);
        push(0, 25'h0000123, 32'h0, 0, 7);
        drain();
        check("idle_busy", {31'd0, busy}, 0);
        check("first_err_count", {24'd0, err_count}, 1);

        stray_req = 1;
        repeat (10) @(posedge clock);
        #1;
        check("stray_idle_busy", {31'd0, busy}, 0);

        push(0, 25'h0000400, 32'h0, 0, 2);
        seen = 0;
        n = 0;
        while (!seen && n < 500) begin
            @(negedge clock);
            seen = rsp_valid;
            n++;
        end
        check("gap_rsp_seen", {31'd0, seen}, 1);
        #1;
        stray_req = 1;
        drain();
        check("stray_gap_busy", {31'd0, busy}, 0);

        for (int i = 0; i < 40; i++) begin
            push(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        drain();
        check("random_busy", {31'd0, busy}, 0);
        check("random_err_count", {24'd0, err_count}, model_errs);

        push(0, addrs[0], 32'h0, 1, 0);
        push(0, addrs[1], 32'h0, 0, 1);
        push(0, addrs[2], 32'h0, 0, 1);
        seen = 0;
        n = 0;
        while (!seen && n < 500) begin
            @(negedge clock);
            seen = mem_request;
            n++;
        end
        while (seen && n < 500) begin
            @(negedge clock);
            seen = mem_request;
            n++;
        end
        check("wait_rsp_reached", {31'd0, n < 500}, 1);
        repeat (5) @(posedge clock);
        #1;
        reset = 1;
        #1;
        check_reset_state("mid");
        exp_q.delete();
        req_q.delete();
        model_errs = 0;
        @(posedge clock);
        #1;
        reset = 0;
        repeat (INIT - 1) @(posedge clock);
        #1;
        check("reinit_pending", {31'd0, init_done}, 0);
        @(posedge clock);
        #1;
        check("reinit_done", {31'd0, init_done}, 1);
        repeat (20) @(posedge clock);
        #1;
        check("discarded_busy", {31'd0, busy}, 0);
        push(1, addrs[3], 32'h13579BDF, 0, 4);
        push(0, addrs[3], 32'h0, 0, 0);
        drain();
        check("final_err_count", {24'd0, err_count}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
